// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: default sizes, FSM encoding
// and the pattern-index wrap helper.
package led_pkg;

  localparam int LED_W_DEF      = 18;
  localparam int NUM_STATES_DEF = 4;
  localparam int MAX_STATES     = 8;
  localparam int IDX_W          = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HANDOFF = 2'd2
  } seq_state_e;

  // Next pattern index, wrapping from the last block back to block 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input int unsigned      count);
    return (idx == IDX_W'(count - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Bundle between the sequencer and its downstream pattern blocks: start/enable
// levels out, done flags and concatenated LED patterns back.
interface led_sequencer_if
  import led_pkg::*;
#(
  parameter int NUM_STATES = NUM_STATES_DEF,
  parameter int LED_W      = LED_W_DEF
);

  logic [NUM_STATES-1:0]       stBegin;
  logic                        enabler;
  logic [NUM_STATES-1:0]       stOver;
  logic [NUM_STATES*LED_W-1:0] stOut;

  modport master (
    output stBegin,
    output enabler,
    input  stOver,
    input  stOut
  );

  modport slave (
    input  stBegin,
    input  enabler,
    output stOver,
    output stOut
  );

endinterface

// File: rtl/led_watchdog.sv
// Saturating 16-bit run-time counter; flags expiry once it reaches TIMEOUT-1
// while enabled, and never wraps.
module led_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic localReset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LIMIT)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge localReset) begin
    if (localReset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = en && (count_q == LIMIT);

endmodule

// File: rtl/led_sequencer.sv
// Pattern sequencer: starts one downstream pattern block at a time, muxes its
// LED pattern onto a registered bus, and forces an advance if a block hangs.
module led_sequencer
  import led_pkg::*;
#(
  parameter int NUM_STATES = NUM_STATES_DEF,
  parameter int LED_W      = LED_W_DEF,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 localReset,
  input  logic                 run,
  led_sequencer_if.master      pat,
  output logic [LED_W-1:0]     out,
  output logic [IDX_W-1:0]     curIdx,
  output logic                 cycleDone,
  output logic                 timeoutErr
);

  seq_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_STATES-1:0]   st_begin_q, st_begin_d;
  logic                    enabler_q, enabler_d;
  logic [LED_W-1:0]        out_q, out_d;
  logic                    cycle_done_q, cycle_done_d;
  logic                    timeout_err_q, timeout_err_d;

  logic                    over_sel;
  logic [LED_W-1:0]        out_sel;
  logic                    wd_clr, wd_en, wd_expire;

  // Done flag and pattern of the active block only; other blocks are ignored.
  always_comb begin
    over_sel = 1'b0;
    out_sel  = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        over_sel = pat.stOver[i];
        out_sel  = pat.stOut[i*LED_W +: LED_W];
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    cycle_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      IDLE: begin
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
        end else if (over_sel) begin
          state_d = HANDOFF;
        end else if (wd_expire) begin
          state_d       = HANDOFF;
          timeout_err_d = 1'b1;
        end
      end
      HANDOFF: begin
        idx_d        = next_idx(idx_q, NUM_STATES);
        cycle_done_d = (idx_q == IDX_W'(NUM_STATES - 1));
        state_d      = run ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from where the FSM lands.
    st_begin_d = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      st_begin_d[i] = (state_d == RUN) && (idx_d == IDX_W'(i));
    end
    enabler_d = (state_d != IDLE);
    out_d     = ((state_q == RUN) && (state_d == RUN)) ? out_sel : '0;

    wd_en  = (state_q == RUN);
    wd_clr = (state_q != RUN) || (state_d != RUN);
  end

  led_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .localReset (localReset),
    .clr        (wd_clr),
    .en         (wd_en),
    .expire     (wd_expire)
  );

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge localReset) begin
    if (localReset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      st_begin_q    <= '0;
      enabler_q     <= 1'b0;
      out_q         <= '0;
      cycle_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      st_begin_q    <= st_begin_d;
      enabler_q     <= enabler_d;
      out_q         <= out_d;
      cycle_done_q  <= cycle_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign pat.stBegin = st_begin_q;
  assign pat.enabler = enabler_q;
  assign out         = out_q;
  assign curIdx      = idx_q;
  assign cycleDone   = cycle_done_q;
  assign timeoutErr  = timeout_err_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: a behavioural model predicts the registered outputs
// for every clock and a scoreboard queue compares them after the edge.
module tb_led_sequencer;

  localparam int N = 4;
  localparam int W = 18;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         localReset;
  logic         run;
  logic [W-1:0] out;
  logic [2:0]   curIdx;
  logic         cycleDone;
  logic         timeoutErr;

  led_sequencer_if #(.NUM_STATES(N), .LED_W(W)) pat ();

  led_sequencer #(
    .NUM_STATES (N),
    .LED_W      (W),
    .TIMEOUT    (T)
  ) dut (
    .clk        (clk),
    .localReset (localReset),
    .run        (run),
    .pat        (pat),
    .out        (out),
    .curIdx     (curIdx),
    .cycleDone  (cycleDone),
    .timeoutErr (timeoutErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] st_begin;
    logic         enabler;
    logic [W-1:0] out;
    logic [2:0]   idx;
    logic         cycle_done;
    logic         timeout_err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model state: 0 idle, 1 run, 2 handoff
  int   m_st, m_idx, m_wd;
  bit   m_err;
  bit   pin0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_idx = 0;
    m_wd  = 0;
    m_err = 1'b0;
  endtask

  task automatic drive_and_predict(input bit r, input logic [N-1:0] ov);
    logic [N*W-1:0] so;
    exp_t           e;
    so = (N*W)'({$urandom(), $urandom(), $urandom()});
    if (pin0) so[W-1:0] = '1;
    run        = r;
    pat.stOver = ov;
    pat.stOut  = so;

    e = '0;
    case (m_st)
      0: begin
        if (r) m_st = 1;
        m_wd = 0;
      end
      1: begin
        if (!r) begin
          m_st = 0; m_wd = 0;
        end else if (ov[m_idx]) begin
          m_st = 2; m_wd = 0;
        end else if (m_wd == T - 1) begin
          m_st = 2; m_wd = 0; m_err = 1'b1;
        end else begin
          e.out = so[m_idx*W +: W];
          m_wd++;
        end
      end
      default: begin
        e.cycle_done = (m_idx == N - 1);
        m_idx        = (m_idx + 1) % N;
        m_st         = r ? 1 : 0;
        m_wd         = 0;
      end
    endcase
    e.st_begin    = (m_st == 1) ? N'(1 << m_idx) : '0;
    e.enabler     = (m_st != 0);
    e.idx         = 3'(m_idx);
    e.timeout_err = m_err;
    sb.push_back(e);
  endtask

  task automatic step(input bit r, input logic [N-1:0] ov);
    exp_t e;
    drive_and_predict(r, ov);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    check($sformatf("c%0d stBegin", cyc),    32'(pat.stBegin), 32'(e.st_begin));
    check($sformatf("c%0d enabler", cyc),    32'(pat.enabler), 32'(e.enabler));
    check($sformatf("c%0d out", cyc),        32'(out),         32'(e.out));
    check($sformatf("c%0d curIdx", cyc),     32'(curIdx),      32'(e.idx));
    check($sformatf("c%0d cycleDone", cyc),  32'(cycleDone),   32'(e.cycle_done));
    check($sformatf("c%0d timeoutErr", cyc), 32'(timeoutErr),  32'(e.timeout_err));
  endtask

  task automatic advance_to(input int target);
    for (int k = 0; k < 40 && !(m_st == 1 && m_idx == target); k++) begin
      if (m_st == 1) step(1'b1, N'(1 << m_idx));
      else           step(1'b1, '0);
    end
    check("reach_idx", 32'(curIdx), 32'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stBegin"},    32'(pat.stBegin), 32'd0);
    check({tag, " enabler"},    32'(pat.enabler), 32'd0);
    check({tag, " out"},        32'(out),         32'd0);
    check({tag, " curIdx"},     32'(curIdx),      32'd0);
    check({tag, " cycleDone"},  32'(cycleDone),   32'd0);
    check({tag, " timeoutErr"}, 32'(timeoutErr),  32'd0);
  endtask

  initial begin
    localReset = 1'b1;
    run        = 1'b0;
    pat.stOver = '0;
    pat.stOut  = '0;
    pin0       = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    localReset = 1'b0;
    @(posedge clk);
    #1;

    // Start-up with block 0 driving all ones, then a normal handoff
    pin0 = 1'b1;
    step(1'b0, '0);
    step(1'b1, '0);
    step(1'b1, '0);
    check("first_out", 32'(out), 32'h3FFFF);
    step(1'b1, '0);
    step(1'b1, 4'b0001);
    step(1'b1, '0);
    pin0 = 1'b0;

    // Blocks 1..3, with stray done flags from inactive blocks, then wrap
    step(1'b1, '0);
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0010);
    step(1'b1, 4'b1000);
    step(1'b1, '0);
    step(1'b1, 4'b0100);
    step(1'b1, '0);
    step(1'b1, 4'b0011);
    step(1'b1, 4'b1000);
    step(1'b1, '0);
    check("wrap_pulse", 32'(cycleDone), 32'd1);
    step(1'b1, '0);

    // Hung blocks: watchdog forces advances and timeoutErr latches
    for (int k = 0; k < 25; k++) step(1'b1, '0);

    // Pause colliding with done at idx 2: pause wins, idx held
    advance_to(2);
    step(1'b0, 4'b0100);
    step(1'b0, '0);
    step(1'b0, '0);
    check("paused_idx", 32'(curIdx), 32'd2);
    step(1'b1, '0);
    check("resume_begin", 32'(pat.stBegin), 32'b0100);

    // Pause arriving during handoff: index still advances
    step(1'b1, 4'b0100);
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b1, '0);

    // Asynchronous reset mid-run at idx 1
    advance_to(1);
    step(1'b1, '0);
    #2;
    localReset = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    run        = 1'b0;
    pat.stOver = '0;
    #2;
    localReset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idx", 32'(curIdx), 32'd0);
    check("post_rst_begin", 32'(pat.stBegin), 32'd0);

    // Randomised traffic
    for (int k = 0; k < 300; k++) begin
      logic [N-1:0] ov;
      ov = ($urandom_range(0, 3) == 0) ? N'($urandom()) : '0;
      step($urandom_range(0, 9) != 0, ov);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
